// File: rtl/mips_mdu.sv
// ---------------------------------------------------------------------------
// mips_mdu: iterative multiply/divide unit for the MIPS execute stage.
//
// Owns the HI/LO register pair. MULT/MULTU use a shift-add loop and DIV/DIVU
// use a restoring divider. Each processes one bit per cycle on operand
// magnitudes. A final FIX cycle applies the sign corrections and writes
// HI/LO. MTHI/MTLO are single-cycle writes that complete while idle.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset; aborts any op and clears HI/LO
//   start  request; accepted only while busy=0
//   op     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   A      rs operand (multiplicand / dividend / MTHI-MTLO source)
//   B      rt operand (multiplier / divisor)
//   busy   high while an arithmetic op is in flight (33 cycles)
//   done   one-cycle pulse after HI/LO are written by an arithmetic op
//   hi     HI register
//   lo     LO register
// ---------------------------------------------------------------------------
module mips_mdu #(
    parameter int XLEN        = 32,
    parameter int MDUOp_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [MDUOp_WIDTH-1:0] op,
    input  logic [XLEN-1:0]        A,
    input  logic [XLEN-1:0]        B,
    output logic                   busy,
    output logic                   done,
    output logic [XLEN-1:0]        hi,
    output logic [XLEN-1:0]        lo
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [MDUOp_WIDTH-1:0] OP_MULT  = MDUOp_WIDTH'(0);
    localparam logic [MDUOp_WIDTH-1:0] OP_MULTU = MDUOp_WIDTH'(1);
    localparam logic [MDUOp_WIDTH-1:0] OP_DIV   = MDUOp_WIDTH'(2);
    localparam logic [MDUOp_WIDTH-1:0] OP_DIVU  = MDUOp_WIDTH'(3);
    localparam logic [MDUOp_WIDTH-1:0] OP_MTHI  = MDUOp_WIDTH'(4);
    localparam logic [MDUOp_WIDTH-1:0] OP_MTLO  = MDUOp_WIDTH'(5);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // Two's-complement magnitude when the op is signed. The magnitude of the
    // most negative value (2^(XLEN-1)) is still representable as an unsigned
    // XLEN-bit number, so the unsigned datapath below handles it cleanly.
    function automatic logic [XLEN-1:0] op_mag(input logic [XLEN-1:0] v, input logic sgn);
        logic signed [XLEN-1:0] sv;
        sv = signed'(v);
        if (sgn && (sv < 0)) begin
            return $unsigned(-sv);
        end
        return v;
    endfunction

    function automatic logic [XLEN-1:0] fix_sign32(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] fix_sign64(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + (2*XLEN)'(1)) : v;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [XLEN-1:0]    hi_q, hi_d;
    logic [XLEN-1:0]    lo_q, lo_d;

    // Shared datapath registers:
    //   MUL: acc = running product, opa = shifting multiplicand, opb = multiplier
    //   DIV: acc = partial remainder, opa[XLEN-1:0] = dividend bits shifting
    //        out / quotient bits shifting in, opb = divisor magnitude
    logic [2*XLEN-1:0]  acc_q, acc_d;
    logic [2*XLEN-1:0]  opa_q, opa_d;
    logic [XLEN-1:0]    opb_q, opb_d;
    logic               neg_q, neg_d;     // negate product / quotient
    logic               rneg_q, rneg_d;   // negate remainder
    logic               div_q, div_d;     // op in flight is a divide

    logic               op_sgn;
    logic [XLEN:0]      div_shift;
    logic [XLEN+1:0]    div_diff;
    logic [2*XLEN-1:0]  prod_fix;
    logic [XLEN-1:0]    quo_fix;
    logic [XLEN-1:0]    rem_fix;

    assign op_sgn = (op == OP_MULT) || (op == OP_DIV);

    // Restoring step: bring the next dividend bit into the remainder and
    // try the subtract. A clear sign bit on the widened difference means the
    // divisor fits, so the quotient bit is 1. With a zero divisor every
    // subtract succeeds. The quotient becomes all ones and the remainder
    // collects the whole dividend, which gives the divide-by-zero result
    // without a special case.
    assign div_shift = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opb_q};

    assign prod_fix = fix_sign64(acc_q, neg_q);
    assign quo_fix  = fix_sign32(opa_q[XLEN-1:0], neg_q);
    assign rem_fix  = fix_sign32(acc_q[XLEN-1:0], rneg_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div_d   = div_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (op)
                        OP_MULT, OP_MULTU: begin
                            acc_d   = '0;
                            opa_d   = {XLEN'(0), op_mag(A, op_sgn)};
                            opb_d   = op_mag(B, op_sgn);
                            neg_d   = op_sgn && (A[XLEN-1] ^ B[XLEN-1]);
                            rneg_d  = 1'b0;
                            div_d   = 1'b0;
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_d   = '0;
                            opa_d   = {XLEN'(0), op_mag(A, op_sgn)};
                            opb_d   = op_mag(B, op_sgn);
                            neg_d   = op_sgn && (A[XLEN-1] ^ B[XLEN-1]);
                            rneg_d  = op_sgn && A[XLEN-1];
                            div_d   = 1'b1;
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            state_d = S_DIV;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;  // reserved encodings are ignored
                    endcase
                end
            end

            S_MUL: begin
                if (opb_q[0]) begin
                    acc_d = acc_q + opa_q;
                end
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = S_FIX;
                end
            end

            S_DIV: begin
                if (!div_diff[XLEN+1]) begin
                    acc_d = {(XLEN-1)'(0), div_diff[XLEN:0]};
                end else begin
                    acc_d = {(XLEN-1)'(0), div_shift};
                end
                opa_d = {XLEN'(0), opa_q[XLEN-2:0], ~div_diff[XLEN+1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (div_q) begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        opa_q  <= opa_d;
        opb_q  <= opb_d;
        neg_q  <= neg_d;
        rneg_q <= rneg_d;
        div_q  <= div_d;
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_mdu.sv
// ---------------------------------------------------------------------------
// tb_mips_mdu: scoreboard bench for mips_mdu. Stimulus pushes the expected
// {hi,lo} of each accepted arithmetic op into a queue. A monitor pops and
// compares on every done pulse and also checks busy length, done width and
// that HI/LO are held while busy.
// ---------------------------------------------------------------------------
module tb_mips_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mips_mdu #(.XLEN(32), .MDUOp_WIDTH(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mhi = 32'h0;
    logic [31:0] mlo = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference: architectural result {hi,lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            3'd0: begin
                q = sa * sb;
                return q;
            end
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'h0) begin
                    q = (sa < 0) ? 64'sd1 : 64'sh0FFFFFFFF;
                    r = sa;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                end
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'h0) begin
                    uq = 64'h0FFFFFFFF;
                    ur = ua;
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                end
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    int          busy_cnt = 0;
    logic        prev_done = 1'b0;
    logic        prev_busy = 1'b0;
    logic [63:0] prev_hilo = 64'h0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (done) begin
            if (prev_done) fail("done_width");
            if (exp_q.size() == 0) begin
                fail("unexpected_done");
            end else begin
                e = exp_q.pop_front();
                check("result_hilo", {hi, lo}, e);
                check("busy_cycles", 64'(busy_cnt), 64'd33);
            end
        end
        if (busy && prev_busy) check("hold_hilo", {hi, lo}, prev_hilo);
        if (busy) busy_cnt++;
        else      busy_cnt = 0;
        prev_done = done;
        prev_busy = busy;
        prev_hilo = {hi, lo};
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) fail("done_timeout");
    endtask

    task automatic run_arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        e = ref_result(o, a, b);
        exp_q.push_back(e);
        issue(o, a, b);
        wait_done();
        {mhi, mlo} = e;
    endtask

    task automatic run_mt(input logic is_lo, input logic [31:0] a);
        if (is_lo) mlo = a;
        else       mhi = a;
        issue(is_lo ? 3'd5 : 3'd4, a, $urandom);
        check("mt_hilo", {hi, lo}, {mhi, mlo});
        check("mt_busy_done", {62'h0, busy, done}, 64'h0);
    endtask

    task automatic expect_quiet(input int cycles, input string name);
        int n_done = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check(name, 64'(n_done), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        A     = 32'h0;
        B     = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_state", {30'h0, busy, done, hi, lo}, 64'h0);
        rst = 1'b0;

        // Directed arithmetic cases
        run_arith(3'd0, 32'hFFFFFFF9, 32'd3);
        check("mult_neg7x3", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_arith(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
        run_arith(3'd2, 32'hFFFFFFF9, 32'd2);
        check("div_neg7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_arith(3'd3, 32'd100, 32'd7);
        check("divu_100_7", {hi, lo}, 64'h00000002_0000000E);
        run_arith(3'd3, 32'd5, 32'd0);
        check("divu_by_zero", {hi, lo}, 64'h00000005_FFFFFFFF);
        run_arith(3'd2, 32'hFFFFFFFB, 32'd0);
        check("div_neg_by_zero", {hi, lo}, 64'hFFFFFFFB_00000001);
        run_arith(3'd2, 32'h80000000, 32'hFFFFFFFF);
        check("div_overflow", {hi, lo}, 64'h00000000_80000000);

        // MTHI while idle, then a reserved op must change nothing
        run_mt(1'b0, 32'h00001234);
        check("mthi_value", {32'h0, hi}, 64'h1234);
        issue(3'd6, $urandom, $urandom);
        check("reserved_ignored", {hi, lo}, {mhi, mlo});
        check("reserved_not_busy", {63'h0, busy}, 64'h0);

        // A second request while busy is dropped, including an MT op
        exp_q.push_back(64'd42);
        issue(3'd0, 32'd6, 32'd7);
        repeat (3) @(negedge clk);
        issue(3'd3, 32'd100, 32'd7);
        issue(3'd5, 32'hDEADBEEF, 32'h0);
        wait_done();
        {mhi, mlo} = 64'd42;
        check("busy_ignore_result", {hi, lo}, 64'd42);
        expect_quiet(40, "no_extra_done");

        // Randomised mix of arithmetic and move ops
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) run_mt(1'($urandom_range(0, 1)), $urandom);
            else run_arith(3'($urandom_range(0, 3)), pick(), pick());
        end

        // Reset at iteration 10 aborts the op and clears HI/LO
        run_mt(1'b1, 32'hA5A5A5A5);
        exp_q.push_back(ref_result(3'd0, 32'h12345, 32'h6789));
        issue(3'd0, 32'h12345, 32'h6789);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_state", {30'h0, busy, done, hi, lo}, 64'h0);
        void'(exp_q.pop_front());
        mhi = 32'h0;
        mlo = 32'h0;
        rst = 1'b0;
        expect_quiet(45, "abort_no_done");
        check("abort_hilo_held", {hi, lo}, 64'h0);

        // Unit still works after the abort
        run_arith(3'd2, 32'd1000, 32'hFFFFFFFD);

        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_mdu.md
Name: mips_mdu

Overview:
- Iterative multiply/divide unit for the MIPS execute stage. It owns the HI/LO register pair.
- Covers the MULT/MULTU/DIV/DIVU/MTHI/MTLO operations that the single-cycle combinational ALU does not.
- Multi-cycle. The pipeline controller stalls MFHI/MFLO and any new MDU op while busy=1.

Parameters:
- XLEN, 32, operand/HI/LO width. Only 32 is supported.
- MDUOp_WIDTH, 3, width of op field.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; accepted only when busy=0
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
- A  input  32  rs operand (multiplicand/dividend; MTHI/MTLO source)
- B  input  32  rt operand (multiplier/divisor)
- busy  output  1  high while an arithmetic op is in flight
- done  output  1  one-cycle pulse: HI/LO just updated by an arithmetic op
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Only one clock and one reset exist. The reset is synchronous and active-high. On rst=1 at a clock edge: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
- rst has priority over everything. Asserting it mid-operation aborts the op, and HI/LO are cleared.
- States:
  - IDLE: wait for start.
  - MUL: shift-add, one bit per cycle.
  - DIV: restoring, one bit per cycle.
  - FIX: sign correction and HI/LO write.
- Accept: at edge E0 with start=1, busy=0, and op an arithmetic op:
  - Capture |A| and |B| (two's-complement magnitude for signed ops; raw value for unsigned ops).
  - Record the result sign(s).
  - Set the counter to 0, busy=1, and enter MUL or DIV.
- Iteration: edges E1..E32 each process one bit. The counter increments every edge. After the 32nd iteration the state goes to FIX.
- FIX, edge E33:
  - Mult: write the 64-bit product, negated if sign(A)^sign(B) for MULT; hi=product[63:32], lo=product[31:0].
  - Div: lo=quotient, negated if sign(A)^sign(B) for DIV. hi=remainder, negated if sign(A) for DIV.
  - Set busy=0, done=1. Return to IDLE.
- Timing: busy is high for exactly 33 cycles. done is high for exactly 1 cycle, after E33, and falls at the next edge.
- A and B are sampled only at E0. Later changes to A and B have no effect on the op in flight.
- MTHI/MTLO: accepted at an edge with start=1 and busy=0. hi (or lo) is loaded with A at that edge. This is single-cycle: busy stays 0 and done is not pulsed.
- Ignored requests (no state change):
  - start while busy=1.
  - A reserved op.
- hi/lo hold their values during an op. They change only at E33, on an MT op, or on reset.
- Divide by zero (B=0): the quotient magnitude is 0xFFFFFFFF and the remainder magnitude is |A|; sign rules then apply.
  - DIVU: lo=0xFFFFFFFF, hi=A.
  - DIV: lo=0xFFFFFFFF if A>=0, else 0x00000001; hi=A.
- DIV overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. The magnitude datapath must be 33-bit clean so that |0x80000000| is handled.
- Width rules:
  - Multiply: 64-bit accumulator.
  - Divide: 33-bit partial remainder for the subtract/compare.
  - All negations are two's complement, modulo 2^64 for the product and 2^32 for the quotient and remainder.

Test Plan:
- Reset: rst=1 → busy=0, done=0, hi=0, lo=0.
- Signed multiply: MULT A=0xFFFFFFF9 (-7), B=3 → after 33 busy cycles, done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Unsigned multiply: MULTU A=B=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Signed and unsigned divide:
  - DIV A=-7, B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU A=100, B=7 → lo=14, hi=2.
- Division corner cases:
  - DIVU A=5, B=0 → lo=0xFFFFFFFF, hi=5.
  - DIV A=-5, B=0 → lo=1, hi=0xFFFFFFFB.
  - DIV 0x80000000 / -1 → lo=0x80000000, hi=0.
- Handshake and abort:
  - Start MULT 6×7, then pulse start with DIVU at cycle 5 → the second request is ignored; result hi=0, lo=42.
  - MTHI A=0x1234 while idle → hi=0x1234 the next cycle, no done pulse.
  - rst asserted at iteration 10 → busy=0, hi=lo=0, done never pulses.
